// File: rtl/gy26_angle_rx.sv
// gy26_angle_rx: polls a GY-26 compass over UART and decodes its ASCII heading frames into BCD.
// Define GY26_CHKSUM_EN to enforce the frame checksum byte.
module gy26_angle_rx #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 9600,
    parameter int POLL_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [9:0] jiaodu,
    output logic       du_en,
    output logic       ang_vld,
    output logic       frame_err
);
    localparam int BIT  = CLK_HZ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int POLL = CLK_HZ / 1000 * POLL_MS;
    localparam int BW   = $clog2(BIT + 1);
    localparam int PW   = $clog2(POLL + 1);
    localparam logic [BW-1:0] BIT_END  = BW'(BIT - 1);
    localparam logic [BW-1:0] HALF_END = BW'(HALF - 1);
    localparam logic [PW-1:0] POLL_END = PW'(POLL - 1);

    logic rx_s1, rx_s2, rx_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {rx_s1, rx_s2, rx_d} <= 3'b111;
        else {rx_s1, rx_s2, rx_d} <= {uart_rx, rx_s1, rx_s2};

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    rx_st_t rx_st, rx_nx;
    logic [BW-1:0] rx_cnt;
    logic [2:0] rx_idx;
    logic [7:0] rx_sh;
    logic rx_bit_end, rx_done, rx_ferr;
    assign rx_bit_end = rx_cnt == BIT_END;

    always_ff @(posedge clk or negedge rst)
        if (!rst) rx_st <= R_IDLE;
        else rx_st <= rx_nx;

    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            R_IDLE:  if (rx_d && !rx_s2) rx_nx = R_START;
            R_START: if (rx_cnt == HALF_END) rx_nx = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_nx = R_STOP;
            default: if (rx_bit_end) rx_nx = R_IDLE;
        endcase
    end

    always_comb begin
        rx_done = rx_st == R_STOP && rx_bit_end && rx_s2;
        rx_ferr = rx_st == R_STOP && rx_bit_end && !rx_s2;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_sh  <= '0;
        end else begin
            rx_cnt <= (rx_st == R_IDLE || rx_st != rx_nx || rx_bit_end) ? '0 : rx_cnt + 1'b1;
            rx_idx <= rx_st == R_IDLE ? '0 : (rx_st == R_DATA && rx_bit_end) ? rx_idx + 1'b1 : rx_idx;
            rx_sh  <= (rx_st == R_DATA && rx_bit_end) ? {rx_s2, rx_sh[7:1]} : rx_sh;
        end

    logic [PW-1:0] poll_cnt;
    logic tick;
    assign tick = poll_cnt == '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) poll_cnt <= '0;
        else poll_cnt <= poll_cnt == POLL_END ? '0 : poll_cnt + 1'b1;

    logic tx_busy;
    logic [BW-1:0] tx_cnt;
    logic [3:0] tx_idx;
    logic [8:0] tx_sh;
    // tx_sh holds the data bits followed by the stop bit; the start bit is driven directly
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (tick) begin
                tx_busy <= 1'b1;
                uart_tx <= 1'b0;
                tx_sh   <= {1'b1, 8'h31};
                tx_cnt  <= '0;
                tx_idx  <= '0;
            end
        end else if (tx_cnt != BIT_END) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt  <= '0;
            tx_idx  <= tx_idx + 1'b1;
            uart_tx <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            if (tx_idx == 4'd9) tx_busy <= 1'b0;
        end

    typedef enum logic [2:0] {HUNT, LF, HUND, TENS, UNITS, DOT, TENTHS, SUM} ps_t;
    ps_t ps, pn;
    logic [7:0] b;
    logic [1:0] h;
    logic [3:0] t, u;
    logic dig, sum_ok, good, accept, err;
    assign b   = rx_sh;
    assign dig = b >= 8'h30 && b <= 8'h39;
`ifdef GY26_CHKSUM_EN
    logic [7:0] sum;
    assign sum_ok = b == sum;
`else
    assign sum_ok = 1'b1;
`endif

    always_comb begin
        good = 1'b0;
        case (ps)
            LF:      good = b == 8'h0A;
            HUND:    good = b >= 8'h30 && b <= 8'h33;
            TENS:    good = dig && !(h == 2'd3 && b > 8'h35);
            UNITS:   good = dig;
            DOT:     good = b == 8'h2E;
            TENTHS:  good = dig;
            SUM:     good = sum_ok;
            default: good = b == 8'h0D;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) ps <= HUNT;
        else ps <= pn;

    // SUM + 1 wraps to HUNT; any rejected byte resyncs on 0x0D
    always_comb begin
        pn = ps;
        if (rx_ferr) pn = HUNT;
        else if (rx_done) pn = good ? ps_t'(3'(ps + 3'd1)) : (b == 8'h0D ? LF : HUNT);
    end

    always_comb begin
        accept = rx_done && ps == SUM && good;
        err    = rx_ferr || (rx_done && ps != HUNT && !good);
    end

    logic [1:0] stale;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            jiaodu    <= '0;
            ang_vld   <= 1'b0;
            frame_err <= 1'b0;
            du_en     <= 1'b0;
            stale     <= '0;
            h         <= '0;
            t         <= '0;
            u         <= '0;
        end else begin
            ang_vld   <= accept;
            frame_err <= err;
            jiaodu    <= accept ? {h, t, u} : jiaodu;
            h         <= (rx_done && good && ps == HUND) ? b[1:0] : h;
            t         <= (rx_done && good && ps == TENS) ? b[3:0] : t;
            u         <= (rx_done && good && ps == UNITS) ? b[3:0] : u;
            if (accept) begin
                du_en <= 1'b1;
                stale <= '0;
            end else if (tick && du_en) begin
                stale <= stale + 1'b1;
                du_en <= stale != 2'd3;
            end
        end

`ifdef GY26_CHKSUM_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) sum <= '0;
        else if (rx_done) sum <= pn == LF ? b : sum + b;
`endif
endmodule

// File: tb/tb_gy26_angle_rx.sv
// tb_gy26_angle_rx: randomized frame-level checks of gy26_angle_rx against a behavioural frame model.
`timescale 1ns/1ps
module tb_gy26_angle_rx;
    localparam int CLK_HZ = 1000000, BAUD = 100000, POLL_MS = 1;
    localparam int BIT = CLK_HZ / BAUD, POLL = CLK_HZ / 1000 * POLL_MS;
`ifdef GY26_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, uart_rx = 1'b1;
    logic uart_tx, du_en, ang_vld, frame_err;
    logic [9:0] jiaodu;
    int checks = 0, errors = 0;
    int cyc = 0, rel_cyc = 0, vld_n = 0, ferr_n = 0, vld_cyc = 0, du_fall_cyc = -1;
    logic du_prev = 1'b0;
    logic [7:0] fr [8];
    logic [9:0] exp_j = '0;

    gy26_angle_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .POLL_MS(POLL_MS)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .jiaodu(jiaodu), .du_en(du_en), .ang_vld(ang_vld), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (ang_vld) begin vld_n++; vld_cyc = cyc; end
        if (frame_err) ferr_n++;
        if (du_prev && !du_en) du_fall_cyc = cyc;
        du_prev = du_en;
    end

    function automatic logic [9:0] bcd(input int v);
        return 10'((v / 100) * 256 + (v / 10 % 10) * 16 + v % 10);
    endfunction

    task set_frame(input logic [7:0] h, input logic [7:0] t, input logic [7:0] u, input logic [7:0] d);
        fr[0] = 8'h0D; fr[1] = 8'h0A; fr[2] = h; fr[3] = t; fr[4] = u; fr[5] = 8'h2E; fr[6] = d;
        fr[7] = 8'h0D + 8'h0A + h + t + u + 8'h2E + d;
    endtask

    task set_heading(input int v, input logic [7:0] d);
        set_frame(8'(48 + v / 100), 8'(48 + v / 10 % 10), 8'(48 + v % 10), d);
    endtask

    task send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0; repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (BIT) @(negedge clk); end
        uart_rx = stop; repeat (BIT) @(negedge clk);
        uart_rx = 1'b1; repeat (1 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task send_frame;
        for (int i = 0; i < 8; i++) send_byte(fr[i], 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task do_reset;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; rel_cyc = cyc; exp_j = '0;
    endtask

    task test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (jiaodu !== 10'h000) begin errors++; $display("FAIL reset_jiaodu: got %h expected 000", jiaodu); end
        checks++; if (du_en !== 1'b0) begin errors++; $display("FAIL reset_du_en: got %b expected 0", du_en); end
        checks++; if (ang_vld !== 1'b0) begin errors++; $display("FAIL reset_ang_vld: got %b expected 0", ang_vld); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst = 1'b1; rel_cyc = cyc;
    endtask

    task test_poll;
        int k, v0, f0;
        logic [7:0] b;
        logic stop;
        do_reset;
        v0 = vld_n; f0 = ferr_n; k = 0;
        while (uart_tx && k < 5) begin @(negedge clk); k++; end
        checks++; if (cyc !== rel_cyc + 1) begin errors++; $display("FAIL poll_first_start: got cycle %0d expected %0d", cyc - rel_cyc, 1); end
        repeat (15) @(negedge clk);
        for (int i = 0; i < 8; i++) begin b[i] = uart_tx; repeat (BIT) @(negedge clk); end
        stop = uart_tx;
        checks++; if ({stop, b} !== 9'h131) begin errors++; $display("FAIL poll_byte: got stop %b data %h expected stop 1 data 31", stop, b); end
        k = 0;
        while (uart_tx && k < 2 * POLL) begin @(negedge clk); k++; end
        checks++; if (cyc !== rel_cyc + 1 + POLL) begin errors++; $display("FAIL poll_period: got cycle %0d expected %0d", cyc - rel_cyc, 1 + POLL); end
        checks++; if ({du_en, 32'(vld_n - v0), 32'(ferr_n - f0)} !== 65'd0) begin errors++; $display("FAIL poll_idle: got du_en %b vld %0d err %0d expected 0 0 0", du_en, vld_n - v0, ferr_n - f0); end
    endtask

    task test_known;
        int v0, f0;
        logic ok;
        for (int n = 0; n < 3; n++) begin
            if (n == 2) set_frame(8'h33, 8'h36, 8'h30, 8'h30);
            else set_frame(8'h31, 8'h32, 8'h33, 8'h34);
            if (n == 1) fr[7] = 8'h10;
            ok = n == 0 || (n == 1 && !CHK);
            v0 = vld_n; f0 = ferr_n;
            send_frame;
            if (ok) exp_j = 10'h123;
            checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL known%0d_jiaodu: got %h expected %h", n, jiaodu, exp_j); end
            checks++; if (vld_n - v0 !== int'(ok)) begin errors++; $display("FAIL known%0d_ang_vld: got %0d expected %0d", n, vld_n - v0, ok); end
            checks++; if (ferr_n - f0 !== int'(!ok)) begin errors++; $display("FAIL known%0d_frame_err: got %0d expected %0d", n, ferr_n - f0, !ok); end
            if (n == 0) begin
                checks++; if (du_en !== 1'b1) begin errors++; $display("FAIL known0_du_en: got %b expected 1", du_en); end
            end
        end
    endtask

    task test_resync;
        int v0, f0;
        v0 = vld_n; f0 = ferr_n;
        send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h31, 1'b1);
        set_heading(245, 8'h30);
        send_frame;
        exp_j = 10'h245;
        checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL resync_jiaodu: got %h expected %h", jiaodu, exp_j); end
        checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL resync_ang_vld: got %0d expected 1", vld_n - v0); end
        checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL resync_frame_err: got %0d expected 1", ferr_n - f0); end
    endtask

    task test_bad_stop;
        int v0, f0, v;
        v0 = vld_n; f0 = ferr_n;
        send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h31, 1'b1); send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b1); send_byte(8'h2E, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h0F, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL badstop_frame_err: got %0d expected 1", ferr_n - f0); end
        checks++; if (vld_n - v0 !== 0) begin errors++; $display("FAIL badstop_ang_vld: got %0d expected 0", vld_n - v0); end
        checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL badstop_jiaodu: got %h expected %h", jiaodu, exp_j); end
        v = $urandom_range(0, 359);
        set_heading(v, 8'h31);
        if (fr[7] == 8'h0D) set_heading(v, 8'h32);
        send_frame;
        exp_j = bcd(v);
        checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL badstop_recover: got %h expected %h", jiaodu, exp_j); end
    endtask

    task test_glitch;
        int v0, f0;
        v0 = vld_n; f0 = ferr_n;
        uart_rx = 1'b0; repeat (2) @(negedge clk);
        uart_rx = 1'b1; repeat (3 * BIT) @(negedge clk);
        checks++; if ((ferr_n - f0) + (vld_n - v0) !== 0) begin errors++; $display("FAIL glitch_ignored: got err %0d vld %0d expected 0 0", ferr_n - f0, vld_n - v0); end
        set_heading(200, 8'h35);
        send_frame;
        exp_j = 10'h200;
        checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL glitch_next_frame: got %h expected %h", jiaodu, exp_j); end
    endtask

    task test_random;
        int v, k, v0, f0;
        logic [7:0] d;
        logic ok;
        for (int n = 0; n < 12; n++) begin
            do begin
                v = $urandom_range(0, 399);
                k = $urandom_range(0, 3);
                d = 8'(48 + $urandom_range(0, 9));
                set_heading(v, k == 3 ? 8'h3A : d);
                if (k == 2) begin fr[5] = 8'h2C; fr[7] = fr[7] - 8'h02; end
                if (k == 1) fr[7] = fr[7] + 8'h01;
            end while (fr[7] == 8'h0D);
            ok = v <= 359 && k != 2 && k != 3 && !(k == 1 && CHK);
            v0 = vld_n; f0 = ferr_n;
            send_frame;
            if (ok) exp_j = bcd(v);
            checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL rand%0d_jiaodu (v=%0d k=%0d): got %h expected %h", n, v, k, jiaodu, exp_j); end
            checks++; if (vld_n - v0 !== int'(ok)) begin errors++; $display("FAIL rand%0d_ang_vld (v=%0d k=%0d): got %0d expected %0d", n, v, k, vld_n - v0, ok); end
            checks++; if (ferr_n - f0 !== int'(!ok)) begin errors++; $display("FAIL rand%0d_frame_err (v=%0d k=%0d): got %0d expected %0d", n, v, k, ferr_n - f0, !ok); end
        end
    endtask

    task test_reset_mid;
        int v0, f0;
        send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h31, 1'b1); send_byte(8'h32, 1'b1);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({jiaodu, du_en} !== 11'd0) begin errors++; $display("FAIL midreset_state: got jiaodu %h du_en %b expected 000 0", jiaodu, du_en); end
        rst = 1'b1; rel_cyc = cyc; exp_j = '0;
        v0 = vld_n; f0 = ferr_n;
        set_heading(45, 8'h30);
        send_frame;
        exp_j = 10'h045;
        checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL midreset_jiaodu: got %h expected %h", jiaodu, exp_j); end
        checks++; if (vld_n - v0 !== 1) begin errors++; $display("FAIL midreset_ang_vld: got %0d expected 1", vld_n - v0); end
        checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL midreset_frame_err: got %0d expected 0", ferr_n - f0); end
        checks++; if (du_en !== 1'b1) begin errors++; $display("FAIL midreset_du_en: got %b expected 1", du_en); end
    endtask

    task test_stale;
        int k, exp_fall;
        set_heading(300, 8'h39);
        if (fr[7] == 8'h0D) set_heading(300, 8'h38);
        du_fall_cyc = -1;
        send_frame;
        exp_j = 10'h300;
        checks++; if ({du_en, jiaodu} !== {1'b1, exp_j}) begin errors++; $display("FAIL stale_fresh: got du_en %b jiaodu %h expected 1 %h", du_en, jiaodu, exp_j); end
        exp_fall = rel_cyc + 1 + ((vld_cyc - rel_cyc - 1) / POLL + 1) * POLL + 3 * POLL;
        k = 0;
        while (du_en && k < 6 * POLL) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        checks++; if (du_en !== 1'b0) begin errors++; $display("FAIL stale_timeout: got du_en %b expected 0", du_en); end
        checks++; if (du_fall_cyc !== exp_fall) begin errors++; $display("FAIL stale_fall_cycle: got %0d expected %0d", du_fall_cyc - rel_cyc, exp_fall - rel_cyc); end
        checks++; if (jiaodu !== exp_j) begin errors++; $display("FAIL stale_jiaodu_hold: got %h expected %h", jiaodu, exp_j); end
    endtask

    initial begin
        test_reset;
        test_poll;
        test_known;
        test_resync;
        test_bad_stop;
        test_glitch;
        test_random;
        test_reset_mid;
        test_stale;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gy26_angle_rx.md
GY26_ANGLE_RX -- requirements
Module: gy26_angle_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate for both TX and RX.
REQ-003 SHALL have parameter POLL_MS, default 100, angle request period in ms.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 uart_rx  input  1  serial data from GY-26 compass, 8N1, asynchronous to clk.
REQ-007 uart_tx  output  1  serial requests to GY-26, 8N1, idle high.
REQ-008 jiaodu  output  10  last valid heading in BCD: [9:8] hundreds, [7:4] tens, [3:0] units, range 0-359.
REQ-009 du_en  output  1  heading-fresh level, consumed by the navigation core.
REQ-010 ang_vld  output  1  one-cycle pulse when jiaodu is updated.
REQ-011 frame_err  output  1  one-cycle pulse when a frame or byte is rejected.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchroniser before any use.
REQ-013 RX SHALL detect a start bit on a falling edge and re-check it low at half a bit time; a high re-check SHALL abort with no byte and no error.
REQ-014 RX SHALL sample data LSB-first at bit centres, with bit time = CLK_HZ/BAUD cycles using integer division.
REQ-015 RX SHALL treat a stop-bit sample of 0 as a framing error: the byte is discarded, frame_err pulses, and the parser returns to HUNT.
REQ-016 TX SHALL send byte 0x31 once per POLL_MS period, with the first send starting 1 cycle after reset release.
REQ-017 TX SHALL never start a new byte while the previous one is in progress.
REQ-018 The parser FSM SHALL use the states HUNT, LF, HUND, TENS, UNITS, DOT, TENTHS and SUM, and SHALL advance one state per received byte.
REQ-019 The required frame SHALL be 0x0D, 0x0A, H, T, U, 0x2E, D, S.
REQ-020 H SHALL be in the range 0x30-0x33, and T, U and D SHALL each be in the range 0x30-0x39.
REQ-021 H*100+T*10+U SHALL be ≤ 359.
REQ-022 S SHALL equal the low 8 bits of the sum of the first 7 frame bytes.
REQ-023 HUNT SHALL move to LF only on 0x0D and SHALL ignore all other bytes without error.
REQ-024 Any mismatch after HUNT SHALL pulse frame_err and return to HUNT; a mismatching byte equal to 0x0D SHALL instead move to LF.
REQ-025 On the cycle after a valid S byte's stop sample, the block SHALL set jiaodu to {H[1:0],T[3:0],U[3:0]}, pulse ang_vld, and discard the tenths digit.
REQ-026 A rejected frame SHALL leave jiaodu unchanged.
REQ-027 du_en SHALL go high with the first ang_vld.
REQ-028 du_en SHALL go low once 4 consecutive poll periods pass with no ang_vld; the count SHALL restart on each ang_vld.
REQ-029 If ang_vld and the stale-count expiry occur in the same cycle, ang_vld SHALL win and du_en SHALL stay high.
REQ-030 All counters SHALL saturate or wrap only at their defined terminal values, with no overflow into adjacent fields.

Reset
REQ-031 On rst low, the block SHALL set uart_tx=1, jiaodu=0, du_en=0, ang_vld=0, frame_err=0, the parser to HUNT, RX and TX to idle, and all timers to 0.
REQ-032 Reset asserted mid-byte or mid-frame SHALL discard partial data; the first frame after release SHALL be parsed from HUNT.

Configuration
REQ-033 Macro GY26_CHKSUM_EN defined: REQ-022 SHALL be enforced, and a mismatch SHALL pulse frame_err.
REQ-034 Macro GY26_CHKSUM_EN undefined: the S byte SHALL be accepted unconditionally, and the checksum adder SHALL not be built.

Verification
REQ-035 Bytes 0D 0A 31 32 33 2E 34 0F -> jiaodu=10'h123, one ang_vld pulse, du_en=1.
REQ-036 Same frame with S=0x10 -> frame_err pulse, jiaodu holds; with GY26_CHKSUM_EN undefined -> jiaodu=10'h123.
REQ-037 Bytes 0D 0A 33 36 30 2E 30 0E -> frame_err pulse, jiaodu unchanged, no ang_vld.
REQ-038 After reset with uart_rx held high -> uart_tx sends 0x31 at t≈0, then every POLL_MS; du_en stays 0.
REQ-039 Valid frame, then silence -> du_en falls exactly at the 4th poll-period boundary after ang_vld.
REQ-040 Reset pulsed after byte 0x32 of a frame, then a full valid frame for 045.0 -> jiaodu=10'h045, with no spurious ang_vld.
